// File: rtl/logic_flag_pkg.sv
// Shared types and defaults for the logical-flag occurrence monitor.
package logic_flag_pkg;

    // Default number of accepted samples per report window.
    localparam int DEFAULT_WINDOW = 16;
    // Default width of each per-flag occurrence counter.
    localparam int DEFAULT_CNT_W  = 8;

    // Monitor control states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    // True when the four flags from the logical-operator stage cannot all
    // have come from the same operand pair:
    //   - AND set while OR clear is impossible;
    //   - AND set means both operands are non-zero, so neither NOT may be set;
    //   - OR clear means both operands are zero, so both NOTs must be set.
    function automatic logic flag_conflict(
        input logic f_and,
        input logic f_or,
        input logic f_nota,
        input logic f_notb
    );
        return (f_and && !f_or) ||
               (f_and && (f_nota || f_notb)) ||
               (!f_or && !(f_nota && f_notb));
    endfunction

endpackage

// File: rtl/logic_flag_monitor_if.sv
// Bundle of the sample-input, report-output and status signals of the
// logical-flag monitor.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both 1. The sample side (in_valid/in_ready) is driven by the
// upstream stage; in_valid may be dropped at any time and a sample only
// counts on a transfer edge. The report side (out_valid/out_ready) is
// driven by the monitor; once out_valid rises it stays 1 and all report
// fields stay stable until the transfer edge.
interface logic_flag_monitor_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic             lo_and;
    logic             lo_or;
    logic             not_a;
    logic             not_b;
    logic [CNT_W-1:0] cnt_and;
    logic [CNT_W-1:0] cnt_or;
    logic [CNT_W-1:0] cnt_nota;
    logic [CNT_W-1:0] cnt_notb;
    logic             out_valid;
    logic             out_ready;
    logic             err;
    logic             busy;

    // Upstream / consumer side.
    modport master (
        output start, in_valid, lo_and, lo_or, not_a, not_b, out_ready,
        input  in_ready, cnt_and, cnt_or, cnt_nota, cnt_notb,
        input  out_valid, err, busy
    );

    // Monitor side.
    modport slave (
        input  start, in_valid, lo_and, lo_or, not_a, not_b, out_ready,
        output in_ready, cnt_and, cnt_or, cnt_nota, cnt_notb,
        output out_valid, err, busy
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
    import logic_flag_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    // Count up on inc, stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {CNT_W{1'b1}})) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/logic_flag_monitor.sv
// Counts how often each logical-operator flag is asserted over a window of
// WINDOW accepted samples, tracks flag consistency, and offers the result
// as a report held until the consumer takes it.
module logic_flag_monitor
    import logic_flag_pkg::*;
#(
    parameter int WINDOW = DEFAULT_WINDOW,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    logic_flag_monitor_if.slave  bus,
    output state_t               dbg_state
);

    localparam int              IDX_W    = $clog2(WINDOW + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             err_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             open_window;
    logic             accept;

    logic [CNT_W-1:0] cnt_and_q;
    logic [CNT_W-1:0] cnt_or_q;
    logic [CNT_W-1:0] cnt_nota_q;
    logic [CNT_W-1:0] cnt_notb_q;

    // in_ready_q is only ever 1 in COUNT, so accept needs no state term.
    assign open_window = (state == IDLE) && bus.start;
    assign accept      = bus.in_valid && in_ready_q;

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= COUNT;
                        idx        <= '0;
                        err_q      <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                COUNT: begin
                    if (accept) begin
                        if (flag_conflict(bus.lo_and, bus.lo_or, bus.not_a, bus.not_b)) begin
                            err_q <= 1'b1;
                        end
                        idx <= idx + IDX_W'(1);
                        // The edge taking the last sample closes the window.
                        if (idx == LAST_IDX) begin
                            state       <= REPORT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                REPORT: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // One saturating counter per flag, cleared when a window opens.
    sat_counter #(.CNT_W(CNT_W)) u_cnt_and (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (open_window),
        .inc   (accept && bus.lo_and),
        .q     (cnt_and_q)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_or (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (open_window),
        .inc   (accept && bus.lo_or),
        .q     (cnt_or_q)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_nota (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (open_window),
        .inc   (accept && bus.not_a),
        .q     (cnt_nota_q)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_notb (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (open_window),
        .inc   (accept && bus.not_b),
        .q     (cnt_notb_q)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.cnt_and   = cnt_and_q;
    assign bus.cnt_or    = cnt_or_q;
    assign bus.cnt_nota  = cnt_nota_q;
    assign bus.cnt_notb  = cnt_notb_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_logic_flag_monitor.sv
// Directed bench for logic_flag_monitor: a WINDOW=4/CNT_W=8 instance for
// the main behaviour and a WINDOW=6/CNT_W=2 instance for saturation.
module tb_logic_flag_monitor;
    import logic_flag_pkg::*;

    logic   clk;
    logic   rst_n;
    state_t st0;
    state_t st1;

    logic_flag_monitor_if #(.CNT_W(8)) bus0 ();
    logic_flag_monitor_if #(.CNT_W(2)) bus1 ();

    logic_flag_monitor #(.WINDOW(4), .CNT_W(8)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus0),
        .dbg_state (st0)
    );

    logic_flag_monitor #(.WINDOW(6), .CNT_W(2)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus1),
        .dbg_state (st1)
    );

    int checks = 0;
    int errors = 0;

    // Expected reports: {cnt_and, cnt_or, cnt_nota, cnt_notb, err}.
    logic [32:0] exp_q0[$];
    logic [8:0]  exp_q1[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flag vector order: {lo_and, lo_or, not_a, not_b}.
    task automatic drive_flags(input int which, input logic [3:0] f, input logic v);
        if (which == 0) begin
            {bus0.lo_and, bus0.lo_or, bus0.not_a, bus0.not_b} = f;
            bus0.in_valid = v;
        end else begin
            {bus1.lo_and, bus1.lo_or, bus1.not_a, bus1.not_b} = f;
            bus1.in_valid = v;
        end
    endtask

    task automatic pulse_start(input int which);
        if (which == 0) bus0.start = 1'b1;
        else            bus1.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    // Present one sample and hold it until it is accepted.
    task automatic send(input int which, input logic [3:0] f);
        logic ok;
        logic rdy;
        ok = 1'b0;
        drive_flags(which, f, 1'b1);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            rdy = (which == 0) ? bus0.in_ready : bus1.in_ready;
            @(posedge clk);
            #1;
            if (rdy) ok = 1'b1;
        end
        drive_flags(which, 4'b0000, 1'b0);
        check("send_accept", ok, 1);
    endtask

    // Raise out_ready until the report has been taken.
    task automatic drain_report(input int which);
        logic done;
        logic ov;
        done = 1'b0;
        if (which == 0) bus0.out_ready = 1'b1;
        else            bus1.out_ready = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            ov = (which == 0) ? bus0.out_valid : bus1.out_valid;
            if (!ov) done = 1'b1;
        end
        tick();
        bus0.out_ready = 1'b0;
        bus1.out_ready = 1'b0;
        check("report_drain", done, 1);
    endtask

    // ---------------- scoreboard monitors ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (bus0.out_valid && bus0.out_ready) begin
                if (exp_q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL report0_unexpected: got report with empty expected queue");
                end else begin
                    check("report0",
                          {bus0.cnt_and, bus0.cnt_or, bus0.cnt_nota, bus0.cnt_notb, bus0.err},
                          exp_q0.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus1.out_valid && bus1.out_ready) begin
                if (exp_q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL report1_unexpected: got report with empty expected queue");
                end else begin
                    check("report1",
                          {bus1.cnt_and, bus1.cnt_or, bus1.cnt_nota, bus1.cnt_notb, bus1.err},
                          exp_q1.pop_front());
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n          = 1'b0;
        bus0.start     = 1'b0;
        bus0.out_ready = 1'b0;
        bus1.start     = 1'b0;
        bus1.out_ready = 1'b0;
        drive_flags(0, 4'b0000, 1'b0);
        drive_flags(1, 4'b0000, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Reset state.
        check("rst_state0",    st0, IDLE);
        check("rst_in_ready",  bus0.in_ready, 0);
        check("rst_out_valid", bus0.out_valid, 0);
        check("rst_busy",      bus0.busy, 0);
        check("rst_err",       bus0.err, 0);
        check("rst_cnt_and",   bus0.cnt_and, 0);
        check("rst_cnt_or",    bus0.cnt_or, 0);
        check("rst_state1",    st1, IDLE);

        // Window 1: start with a simultaneous sample that must be ignored,
        // then operand pairs (1,7) (5,1) (0,0) (8,3).
        tick();
        bus0.start = 1'b1;
        drive_flags(0, 4'b1111, 1'b1);
        tick();
        bus0.start = 1'b0;
        drive_flags(0, 4'b0000, 1'b0);
        check("w1_in_ready_open", bus0.in_ready, 1);
        check("w1_busy_open",     bus0.busy, 1);
        check("w1_start_sample_ignored", bus0.cnt_and, 0);
        exp_q0.push_back({8'd3, 8'd3, 8'd1, 8'd1, 1'b0});
        send(0, 4'b1100);
        send(0, 4'b1100);
        send(0, 4'b0011);
        check("w1_no_valid_before_last", bus0.out_valid, 0);
        send(0, 4'b1100);
        check("w1_out_valid_next_cycle", bus0.out_valid, 1);
        check("w1_in_ready_report", bus0.in_ready, 0);
        check("w1_state_report", st0, REPORT);
        drain_report(0);
        check("w1_idle_state", st0, IDLE);
        check("w1_idle_busy", bus0.busy, 0);
        check("w1_idle_cnt_and_held", bus0.cnt_and, 3);
        check("w1_idle_cnt_nota_held", bus0.cnt_nota, 1);

        // Window 2: one inconsistent sample (AND without OR) sets err.
        pulse_start(0);
        exp_q0.push_back({8'd2, 8'd3, 8'd0, 8'd2, 1'b1});
        send(0, 4'b1000);
        check("w2_err_set", bus0.err, 1);
        send(0, 4'b0101);
        send(0, 4'b0101);
        send(0, 4'b1100);
        check("w2_err_in_report", bus0.err, 1);
        drain_report(0);
        check("w2_err_in_idle", bus0.err, 1);
        pulse_start(0);
        check("w3_err_cleared", bus0.err, 0);
        check("w3_cnt_cleared", bus0.cnt_or, 0);

        // Window 3: in_valid gaps, then REPORT held with out_ready low
        // while start and in_valid are driven.
        exp_q0.push_back({8'd3, 8'd3, 8'd1, 8'd1, 1'b0});
        send(0, 4'b1100);
        tick();
        tick();
        send(0, 4'b1100);
        tick();
        send(0, 4'b0011);
        tick();
        tick();
        tick();
        check("w3_gap_cnt_and", bus0.cnt_and, 2);
        send(0, 4'b1100);
        bus0.start = 1'b1;
        drive_flags(0, 4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("w3_hold_out_valid", bus0.out_valid, 1);
            check("w3_hold_in_ready", bus0.in_ready, 0);
            check("w3_hold_cnt_and", bus0.cnt_and, 3);
            check("w3_hold_cnt_or", bus0.cnt_or, 3);
            check("w3_hold_state", st0, REPORT);
        end
        tick();
        bus0.start = 1'b0;
        drive_flags(0, 4'b0000, 1'b0);
        drain_report(0);
        check("w3_idle_state", st0, IDLE);
        check("w3_idle_cnt_notb", bus0.cnt_notb, 1);

        // Narrow counters: OR on every sample saturates at 3.
        pulse_start(1);
        exp_q1.push_back({2'd0, 2'd3, 2'd0, 2'd0, 1'b0});
        for (int i = 0; i < 6; i++) begin
            send(1, 4'b0100);
            if (i == 1) check("sat_cnt_or_2", bus1.cnt_or, 2);
            if (i >= 2) check("sat_cnt_or_held", bus1.cnt_or, 3);
        end
        check("sat_out_valid", bus1.out_valid, 1);
        drain_report(1);

        // Reset in the middle of a window.
        pulse_start(0);
        send(0, 4'b1100);
        send(0, 4'b1100);
        check("mid_cnt_and", bus0.cnt_and, 2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", st0, IDLE);
        check("arst_cnt_and", bus0.cnt_and, 0);
        check("arst_cnt_or", bus0.cnt_or, 0);
        check("arst_in_ready", bus0.in_ready, 0);
        check("arst_busy", bus0.busy, 0);
        check("arst_out_valid", bus0.out_valid, 0);
        check("arst_err", bus0.err, 0);
        tick();
        rst_n = 1'b1;
        drive_flags(0, 4'b1111, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_in_ready", bus0.in_ready, 0);
        end
        tick();
        drive_flags(0, 4'b0000, 1'b0);
        check("post_rst_cnt_and", bus0.cnt_and, 0);
        check("post_rst_state", st0, IDLE);

        repeat (3) tick();
        check("q0_drained", exp_q0.size(), 0);
        check("q1_drained", exp_q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_flag_monitor.md
LOGIC_FLAG_MONITOR -- requirements
Module: logic_flag_monitor

Interface
REQ-001 SHALL have parameter WINDOW, default 16, meaning the number of flag samples per report window (legal range 1..255).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of each per-flag occurrence counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request to open a window; honoured only in IDLE.
REQ-006 SHALL have port in_valid, input, 1, meaning a flag sample is present this cycle.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts a sample this cycle.
REQ-008 SHALL have ports lo_and, lo_or, not_a, not_b, input, 1 each, the flags produced by the upstream logical-operator stage.
REQ-009 SHALL have ports cnt_and, cnt_or, cnt_nota, cnt_notb, output, CNT_W each, the per-flag assertion counts for the last window.
REQ-010 SHALL have port out_valid, input/output handshake pair out_valid (output, 1) and out_ready (input, 1) qualifying the report.
REQ-011 SHALL have port err, output, 1, a sticky flag-consistency error for the current window.
REQ-012 SHALL have port busy, output, 1, high in COUNT or REPORT.

Function
REQ-013 SHALL implement the FSM states IDLE, COUNT and REPORT.
REQ-014 SHALL go IDLE->COUNT on start, clearing all counters, the sample index and err in the same edge.
REQ-015 SHALL drive in_ready=1 only in COUNT; a sample is accepted when in_valid && in_ready.
REQ-016 SHALL, on each accepted sample, increment each counter whose flag is 1, saturating at 2^CNT_W-1 (no wrap).
REQ-017 SHALL set err (sticky until the next start) on an accepted sample where any of the following holds: lo_and && !lo_or; lo_and && (not_a || not_b); !lo_or && !(not_a && not_b).
REQ-018 SHALL go COUNT->REPORT on the edge that accepts sample number WINDOW; the counts reflect all WINDOW samples, and out_valid rises the next cycle.
REQ-019 SHALL hold out_valid and keep all count outputs stable in REPORT until out_ready=1; REPORT->IDLE on out_valid && out_ready.
REQ-020 SHALL ignore start in COUNT and REPORT, and SHALL ignore in_valid outside COUNT.
REQ-021 SHALL keep counts and err visible after returning to IDLE until the next start.
REQ-022 SHALL leave cycles with in_valid=0 in COUNT without effect; the window measures samples, not cycles.

Reset
REQ-023 SHALL, when rst_n=0, immediately force state=IDLE, all counters=0, sample index=0, err=0, out_valid=0, in_ready=0 and busy=0, including mid-window.
REQ-024 SHALL need a fresh start after reset release before accepting samples.

Structure
REQ-025 SHALL place the state enum type and the default WINDOW and CNT_W constants in the shared package logic_flag_pkg.
REQ-026 SHALL instantiate the sub-module sat_counter (parameter CNT_W; inputs clr and inc; output q, saturating) four times, once per flag.
REQ-027 SHALL size the sample index at $clog2(WINDOW+1) bits.

Verification
REQ-028 SHALL cover: WINDOW=4, start, then samples (a,b) = (1,7), (5,1), (0,0), (8,3) applied as their flags -> cnt_and=3, cnt_or=3, cnt_nota=1, cnt_notb=1, err=0, and out_valid 1 cycle after the 4th accept.
REQ-029 SHALL cover: inject lo_and=1 with lo_or=0 on one sample -> err=1 and held through REPORT; the next start clears it.
REQ-030 SHALL cover: CNT_W=2, WINDOW=6, lo_or=1 on all samples -> cnt_or=3 (saturated), no wrap.
REQ-031 SHALL cover: in_valid gaps and out_ready held low for 5 cycles in REPORT -> counts unchanged, out_valid stays 1, in_ready=0, and start is ignored.
REQ-032 SHALL cover: rst_n asserted after 2 of 4 samples -> all outputs 0 asynchronously, and after release no accept occurs without start.
REQ-033 SHALL cover: start and in_valid high in the same IDLE cycle -> that sample is not counted, and counting begins the next cycle.
